// File: rtl/data_path_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset datapath:
// state encodings, opcodes, ALU codes, immediate generator and ALU.
package data_path_mc_pkg;

  localparam int PC_W       = 8;
  localparam int INS_W      = 32;
  localparam int RF_ADDRESS = 5;
  localparam int DATA_W     = 32;
  localparam int DM_ADDRESS = 9;
  localparam int ALU_CC_W   = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [ALU_CC_W-1:0] CC_AND  = 4'b0000;
  localparam logic [ALU_CC_W-1:0] CC_OR   = 4'b0001;
  localparam logic [ALU_CC_W-1:0] CC_ADD  = 4'b0010;
  localparam logic [ALU_CC_W-1:0] CC_XOR  = 4'b0011;
  localparam logic [ALU_CC_W-1:0] CC_SUB  = 4'b0110;
  localparam logic [ALU_CC_W-1:0] CC_SLT  = 4'b0111;
  localparam logic [ALU_CC_W-1:0] CC_SLL  = 4'b1000;
  localparam logic [ALU_CC_W-1:0] CC_SRL  = 4'b1001;
  localparam logic [ALU_CC_W-1:0] CC_SRA  = 4'b1010;
  localparam logic [ALU_CC_W-1:0] CC_SLTU = 4'b1011;
  localparam logic [ALU_CC_W-1:0] CC_PASB = 4'b1101;

  // Branch immediates are kept in half-word units; the PC adder shifts them.
  function automatic logic [DATA_W-1:0] imm_gen(
    input logic [INS_W-1:0] ir
  );
    logic [DATA_W-1:0] imm;
    imm = '0;
    case (ir[6:0])
      OP_I, OP_LD, OP_JALR:
        imm = {{20{ir[31]}}, ir[31:20]};
      OP_ST:
        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BR:
        imm = {{20{ir[31]}}, ir[31], ir[7],
               ir[30:25], ir[11:8]};
      OP_LUI:
        imm = {ir[31:12], 12'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic [DATA_W-1:0] alu(
    input logic [DATA_W-1:0]   a,
    input logic [DATA_W-1:0]   b,
    input logic [ALU_CC_W-1:0] cc
  );
    logic [DATA_W-1:0] y;
    y = '0;
    case (cc)
      CC_AND:  y = a & b;
      CC_OR:   y = a | b;
      CC_ADD:  y = a + b;
      CC_XOR:  y = a ^ b;
      CC_SUB:  y = a - b;
      CC_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      CC_SLTU: y = {31'b0, a < b};
      CC_SLL:  y = a << b[4:0];
      CC_SRL:  y = a >> b[4:0];
      CC_SRA:  y = DATA_W'($signed(a) >>> b[4:0]);
      CC_PASB: y = b;
      default: y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/data_path_mc_sequencer.sv
// Multi-cycle sequencer: state register, next-state logic,
// data-memory strobes and the retire pulse.
module data_path_mc_sequencer
  import data_path_mc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_imem_valid,
  input  logic       i_dm_ready,
  input  logic       i_branch,
  input  logic       i_mem_read,
  input  logic       i_mem_write,
  input  logic       i_reg_write,
  output logic [2:0] o_state,
  output logic       o_dm_we,
  output logic       o_dm_re,
  output logic       o_instr_done,
  output logic       o_retire
);

  state_e r_state;
  logic   r_dm_we;
  logic   r_dm_re;
  logic   r_done;
  logic   w_retire;
  logic   w_mem;

  assign w_mem = i_mem_read | i_mem_write;

  always_comb begin
    w_retire = 1'b0;
    unique case (r_state)
      ST_EXEC: w_retire = i_branch | ~(w_mem | i_reg_write);
      ST_MEM:  w_retire = i_dm_ready & i_mem_write;
      ST_WB:   w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_FETCH;
      r_dm_we <= 1'b0;
      r_dm_re <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_retire;
      unique case (r_state)
        ST_FETCH:
          if (i_imem_valid) r_state <= ST_DECODE;
        ST_DECODE:
          r_state <= ST_EXEC;
        ST_EXEC:
          if (i_branch) begin
            r_state <= ST_FETCH;
          end else if (w_mem) begin
            r_state <= ST_MEM;
            r_dm_we <= i_mem_write;
            r_dm_re <= ~i_mem_write;
          end else if (i_reg_write) begin
            r_state <= ST_WB;
          end else begin
            r_state <= ST_FETCH;
          end
        ST_MEM:
          if (i_dm_ready) begin
            r_dm_we <= 1'b0;
            r_dm_re <= 1'b0;
            r_state <= i_mem_write ? ST_FETCH : ST_WB;
          end
        ST_WB:
          r_state <= ST_FETCH;
        default:
          r_state <= ST_FETCH;
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_dm_we      = r_dm_we;
  assign o_dm_re      = r_dm_re;
  assign o_instr_done = r_done;
  assign o_retire     = w_retire;

endmodule

// File: rtl/data_path_mc.sv
// Multi-cycle RV32I-subset datapath with latched IR/A/B/ALUOut/MDR
// and wait-state handshakes on instruction and data memory.
module data_path_mc
  import data_path_mc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [INS_W-1:0]      imem_rdata,
  input  logic                  imem_valid,
  input  logic                  reg_write,
  input  logic                  mem2reg,
  input  logic                  alu_src,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic                  branch,
  input  logic [ALU_CC_W-1:0]   alu_cc,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [DM_ADDRESS-1:0] dm_addr,
  output logic [DATA_W-1:0]     dm_wdata,
  output logic                  dm_we,
  output logic                  dm_re,
  input  logic [DATA_W-1:0]     dm_rdata,
  input  logic                  dm_ready,
  output logic [DATA_W-1:0]     alu_result,
  output logic [2:0]            stage,
  output logic                  instr_done
);

  logic [PC_W-1:0]     r_pc;
  logic [INS_W-1:0]    r_ir;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_alu;
  logic [DATA_W-1:0]   r_mdr;
  logic [DATA_W-1:0]   r_rf [32];
  logic                r_reg_write;
  logic                r_mem2reg;
  logic                r_alu_src;
  logic                r_mem_write;
  logic                r_mem_read;
  logic                r_branch;
  logic [ALU_CC_W-1:0] r_alu_cc;

  logic [2:0]            w_stage;
  state_e                w_state;
  logic                  w_retire;
  logic                  w_taken;
  logic [DATA_W-1:0]     w_imm;
  logic [DATA_W-1:0]     w_opb;
  logic [PC_W-1:0]       w_boff;
  logic [RF_ADDRESS-1:0] w_rs1;
  logic [RF_ADDRESS-1:0] w_rs2;
  logic [RF_ADDRESS-1:0] w_rd;

  assign w_state = state_e'(w_stage);
  assign w_rs1   = r_ir[19:15];
  assign w_rs2   = r_ir[24:20];
  assign w_rd    = r_ir[11:7];
  assign w_imm   = imm_gen(r_ir);
  assign w_opb   = r_alu_src ? w_imm : r_b;
  assign w_boff  = {w_imm[PC_W-2:0], 1'b0};
  assign w_taken = (w_state == ST_EXEC) & r_branch
                 & (r_a == r_b);

  data_path_mc_sequencer u_seq (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_imem_valid (imem_valid),
    .i_dm_ready   (dm_ready),
    .i_branch     (r_branch),
    .i_mem_read   (r_mem_read),
    .i_mem_write  (r_mem_write),
    .i_reg_write  (r_reg_write),
    .o_state      (w_stage),
    .o_dm_we      (dm_we),
    .o_dm_re      (dm_re),
    .o_instr_done (instr_done),
    .o_retire     (w_retire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_alu       <= '0;
      r_mdr       <= '0;
      r_reg_write <= 1'b0;
      r_mem2reg   <= 1'b0;
      r_alu_src   <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_branch    <= 1'b0;
      r_alu_cc    <= '0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      unique case (w_state)
        ST_FETCH:
          if (imem_valid) r_ir <= imem_rdata;
        ST_DECODE: begin
          r_a         <= (w_rs1 == '0) ? '0 : r_rf[w_rs1];
          r_b         <= (w_rs2 == '0) ? '0 : r_rf[w_rs2];
          r_reg_write <= reg_write;
          r_mem2reg   <= mem2reg;
          r_alu_src   <= alu_src;
          r_mem_write <= mem_write;
          r_mem_read  <= mem_read;
          r_branch    <= branch;
          r_alu_cc    <= alu_cc;
        end
        ST_EXEC:
          r_alu <= alu(r_a, w_opb, r_alu_cc);
        ST_MEM:
          if (dm_ready && !r_mem_write) r_mdr <= dm_rdata;
        ST_WB:
          if (w_rd != '0)
            r_rf[w_rd] <= r_mem2reg ? r_mdr : r_alu;
        default: ;
      endcase
      if (w_retire)
        r_pc <= w_taken ? r_pc + w_boff : r_pc + PC_W'(4);
    end
  end

  assign imem_addr  = r_pc;
  assign opcode     = r_ir[6:0];
  assign funct3     = r_ir[14:12];
  assign funct7     = r_ir[31:25];
  assign dm_addr    = r_alu[DM_ADDRESS-1:0];
  assign dm_wdata   = r_b;
  assign alu_result = r_alu;
  assign stage      = w_stage;

endmodule

// File: tb/tb_data_path_mc.sv
// Directed bench for data_path_mc: bench-side controller,
// instruction ROM and wait-state data memory.
module tb_data_path_mc;
  import data_path_mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid = 1'b1;
  logic        reg_write, mem2reg, alu_src;
  logic        mem_write, mem_read, branch;
  logic [3:0]  alu_cc;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [8:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata, alu_result;
  logic        dm_we, dm_re, dm_ready;
  logic [2:0]  stage;
  logic        instr_done;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  int          dm_wait = 0;
  int          dm_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [31:0] last_wdata = '0;

  always #5 clk = ~clk;

  data_path_mc dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid),
    .reg_write(reg_write), .mem2reg(mem2reg),
    .alu_src(alu_src), .mem_write(mem_write),
    .mem_read(mem_read), .branch(branch),
    .alu_cc(alu_cc), .opcode(opcode),
    .funct3(funct3), .funct7(funct7),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_we(dm_we), .dm_re(dm_re),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .alu_result(alu_result), .stage(stage),
    .instr_done(instr_done)
  );

  assign imem_rdata = imem[imem_addr[7:2]];
  assign dm_rdata   = dmem[dm_addr[5:2]];
  assign dm_ready   = (dm_we || dm_re) && (dm_cnt >= dm_wait);

  always @(posedge clk) begin
    if ((dm_we || dm_re) && !dm_ready) dm_cnt <= dm_cnt + 1;
    else dm_cnt <= 0;
    if (dm_we && dm_ready) dmem[dm_addr[5:2]] <= dm_wdata;
  end

  // External controller stand-in
  always_comb begin
    reg_write = 1'b0; mem2reg = 1'b0; alu_src = 1'b0;
    mem_write = 1'b0; mem_read = 1'b0; branch = 1'b0;
    alu_cc = CC_ADD;
    case (opcode)
      7'h13: begin reg_write = 1'b1; alu_src = 1'b1; end
      7'h33: begin
        reg_write = 1'b1;
        alu_cc = funct7[5] ? CC_SUB : CC_ADD;
      end
      7'h03: begin
        reg_write = 1'b1; mem2reg = 1'b1;
        alu_src = 1'b1; mem_read = 1'b1;
      end
      7'h23: begin alu_src = 1'b1; mem_write = 1'b1; end
      7'h63: begin branch = 1'b1; alu_cc = CC_SUB; end
      default: ;
    endcase
  end

  task automatic wait_done(input int maxc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (dm_we) begin
        we_cnt++;
        last_wdata = dm_wdata;
      end
      if (instr_done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_addr !== 8'd0) begin
      errors++; $display("FAIL rst_pc: got %0d want 0", imem_addr);
    end
    checks++;
    if (stage !== 3'd0) begin
      errors++; $display("FAIL rst_stage: got %0d want 0", stage);
    end
    checks++;
    if (alu_result !== 32'd0) begin
      errors++; $display("FAIL rst_alu: got %0d want 0", alu_result);
    end
    checks++;
    if ({dm_we, dm_re, instr_done} !== 3'b000) begin
      errors++;
      $display("FAIL rst_strobes: got %b want 000",
               {dm_we, dm_re, instr_done});
    end
    reset = 1'b1;
  endtask

  task automatic test_alu_ops;
    int cyc;
    wait_done(20, cyc);
    checks++;
    if (cyc !== 4 || alu_result !== 32'd5) begin
      errors++;
      $display("FAIL addi: cyc %0d alu %0d want 4/5", cyc, alu_result);
    end
    wait_done(20, cyc);
    checks++;
    if (cyc !== 4 || alu_result !== 32'd10) begin
      errors++;
      $display("FAIL add: cyc %0d alu %0d want 4/10", cyc, alu_result);
    end
    checks++;
    if (imem_addr !== 8'd8) begin
      errors++; $display("FAIL add_pc: got %0d want 8", imem_addr);
    end
  endtask

  task automatic test_store_load;
    int cyc;
    dm_wait = 3; we_cnt = 0;
    wait_done(30, cyc);
    checks++;
    if (cyc !== 7 || we_cnt !== 4) begin
      errors++;
      $display("FAIL sw_wait: cyc %0d we %0d want 7/4", cyc, we_cnt);
    end
    checks++;
    if (last_wdata !== 32'd10 || dmem[0] !== 32'd10) begin
      errors++;
      $display("FAIL sw_data: got %0d/%0d want 10",
               last_wdata, dmem[0]);
    end
    dm_wait = 0;
    wait_done(20, cyc);
    checks++;
    if (cyc !== 5 || imem_addr !== 8'd16) begin
      errors++;
      $display("FAIL lw: cyc %0d pc %0d want 5/16", cyc, imem_addr);
    end
    wait_done(20, cyc);
    checks++;
    if (alu_result !== 32'd10) begin
      errors++; $display("FAIL lw_x3: got %0d want 10", alu_result);
    end
  endtask

  task automatic test_branch;
    int cyc;
    wait_done(20, cyc);
    checks++;
    if (cyc !== 3 || imem_addr !== 8'd28) begin
      errors++;
      $display("FAIL beq_taken: cyc %0d pc %0d want 3/28",
               cyc, imem_addr);
    end
    wait_done(20, cyc);
    checks++;
    if (cyc !== 3 || imem_addr !== 8'd32) begin
      errors++;
      $display("FAIL beq_not: cyc %0d pc %0d want 3/32",
               cyc, imem_addr);
    end
    wait_done(20, cyc);
    checks++;
    if (imem_addr !== 8'd252) begin
      errors++; $display("FAIL beq_far: got %0d want 252", imem_addr);
    end
    wait_done(20, cyc);
    checks++;
    if (imem_addr !== 8'd0 || alu_result !== 32'd7) begin
      errors++;
      $display("FAIL wrap: pc %0d alu %0d want 0/7",
               imem_addr, alu_result);
    end
  endtask

  task automatic test_imem_wait;
    int cyc;
    imem_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (stage !== 3'd0 || imem_addr !== 8'd0 ||
          dm_we !== 1'b0 || dm_re !== 1'b0) begin
        errors++;
        $display("FAIL ifetch_hold: stage %0d pc %0d want 0/0",
                 stage, imem_addr);
      end
    end
    imem_valid = 1'b1;
    wait_done(20, cyc);
    checks++;
    if (cyc !== 4 || alu_result !== 32'd5) begin
      errors++;
      $display("FAIL after_wait: cyc %0d alu %0d want 4/5",
               cyc, alu_result);
    end
  endtask

  task automatic test_reset_mid_mem;
    int cyc;
    bit seen;
    wait_done(20, cyc);
    dm_wait = 20;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (dm_we) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL mid_mem_we: got 0 want 1");
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dm_we !== 1'b0 || stage !== 3'd0 || imem_addr !== 8'd0) begin
      errors++;
      $display("FAIL async_rst: we %0d stage %0d pc %0d want 0",
               dm_we, stage, imem_addr);
    end
    imem[0] = 32'h00208233;
    imem[1] = 32'h00318233;
    dm_wait = 0;
    @(negedge clk);
    reset = 1'b1;
    wait_done(20, cyc);
    checks++;
    if (cyc !== 4 || alu_result !== 32'd0) begin
      errors++;
      $display("FAIL rf_clr12: cyc %0d alu %0d want 4/0",
               cyc, alu_result);
    end
    wait_done(20, cyc);
    checks++;
    if (alu_result !== 32'd0 || imem_addr !== 8'd8) begin
      errors++;
      $display("FAIL rf_clr3: alu %0d pc %0d want 0/8",
               alu_result, imem_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
    imem[0]  = 32'h00500093;
    imem[1]  = 32'h00108133;
    imem[2]  = 32'h00202023;
    imem[3]  = 32'h00002183;
    imem[4]  = 32'h00018233;
    imem[5]  = 32'h00108463;
    imem[7]  = 32'h00208463;
    imem[8]  = 32'h0C000E63;
    imem[63] = 32'h00700293;
    test_reset;
    test_alu_ops;
    test_store_load;
    test_branch;
    test_imem_wait;
    test_reset_mid_mem;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
